// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : intersection_scheduler
// Purpose  : Two-approach right-of-way scheduler. Sequences green, yellow,
//            walk and all-red phases, alternating ownership round-robin, with
//            phase lengths counted in ticks from the external blinker.
// Revision : 1.0  initial release
// ============================================================================
module intersection_scheduler #(
    parameter int C_MIN_GREEN = 50,
    parameter int C_MAX_GREEN = 200,
    parameter int C_YELLOW    = 20,
    parameter int C_ALLRED    = 10,
    parameter int C_WALK      = 100
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       blink,
    input  logic       inTrafficA,
    input  logic       inTrafficB,
    input  logic       inPedA,
    input  logic       inPedB,
    input  logic       inHold,
    output logic [1:0] outLightA,
    output logic [1:0] outLightB,
    output logic [1:0] outPedLatch,
    output logic       outOwner
);

    // State codes are chosen equal to the light codes so the owner light is a
    // direct copy of the state register.
    localparam logic [1:0] c_ST_ALLRED = 2'b00;
    localparam logic [1:0] c_ST_GREEN  = 2'b01;
    localparam logic [1:0] c_ST_YELLOW = 2'b10;
    localparam logic [1:0] c_ST_WALK   = 2'b11;

    localparam logic [7:0] c_MIN_GREEN = 8'(C_MIN_GREEN);
    localparam logic [7:0] c_MAX_GREEN = 8'(C_MAX_GREEN);
    localparam logic [7:0] c_YELLOW    = 8'(C_YELLOW);
    localparam logic [7:0] c_ALLRED    = 8'(C_ALLRED);
    localparam logic [7:0] c_WALK      = 8'(C_WALK);

    logic [5:0] w_asyncIn;
    logic [5:0] r_sync1;
    logic [5:0] r_sync2;
    logic       w_blinkS;
    logic       w_trafficAS;
    logic       w_trafficBS;
    logic       w_pedAS;
    logic       w_pedBS;
    logic       w_holdS;

    logic       r_blinkPrev;
    logic       w_tick;

    logic [1:0] r_state;
    logic [1:0] w_nextState;
    logic       r_owner;
    logic       w_nextOwner;
    logic [7:0] r_timer;
    logic [1:0] r_pedLatch;

    logic       w_demandA;
    logic       w_demandB;
    logic       w_demandOwn;
    logic       w_demandOther;
    logic       w_grantOwner;
    logic       w_grantPed;

    assign w_asyncIn = {inHold, inPedB, inPedA, inTrafficB, inTrafficA, blink};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_asyncIn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_blinkS    = r_sync2[0];
    assign w_trafficAS = r_sync2[1];
    assign w_trafficBS = r_sync2[2];
    assign w_pedAS     = r_sync2[3];
    assign w_pedBS     = r_sync2[4];
    assign w_holdS     = r_sync2[5];

    // Edge detect on the synchronised blink: one tick per rise regardless of high time.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_blinkPrev <= 1'b0;
        end else begin
            r_blinkPrev <= w_blinkS;
        end
    end

    assign w_tick = w_blinkS & ~r_blinkPrev;

    assign w_demandA     = w_trafficAS | r_pedLatch[0];
    assign w_demandB     = w_trafficBS | r_pedLatch[1];
    assign w_demandOwn   = r_owner ? w_demandB : w_demandA;
    assign w_demandOther = r_owner ? w_demandA : w_demandB;

    // Hand over unless the owner alone still wants the crossing.
    assign w_grantOwner = (w_demandOther | ~w_demandOwn) ? ~r_owner : r_owner;
    assign w_grantPed   = w_grantOwner ? r_pedLatch[1] : r_pedLatch[0];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= c_ST_ALLRED;
            r_owner <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_owner <= w_nextOwner;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        case (r_state)
            c_ST_ALLRED: begin
                if ((r_timer >= c_ALLRED) && !w_holdS) begin
                    w_nextOwner = w_grantOwner;
                    w_nextState = w_grantPed ? c_ST_WALK : c_ST_GREEN;
                end
            end
            c_ST_GREEN: begin
                if ((r_timer >= c_MAX_GREEN) ||
                    ((r_timer >= c_MIN_GREEN) && w_demandOther)) begin
                    w_nextState = c_ST_YELLOW;
                end
            end
            c_ST_YELLOW: begin
                if (r_timer >= c_YELLOW) begin
                    w_nextState = c_ST_ALLRED;
                end
            end
            c_ST_WALK: begin
                if (r_timer >= c_WALK) begin
                    w_nextState = c_ST_ALLRED;
                end
            end
            default: begin
                w_nextState = c_ST_ALLRED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_timer <= 8'd0;
        end else if (w_nextState != r_state) begin
            r_timer <= 8'd0;
        end else if (w_tick && (r_timer != 8'hFF)) begin
            r_timer <= r_timer + 8'd1;
        end
    end

    // Walk service for an approach clears its latch and outranks a new press.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_pedLatch <= 2'b00;
        end else begin
            r_pedLatch[0] <= ((r_state == c_ST_WALK) && !r_owner) ? 1'b0
                                                                  : (r_pedLatch[0] | w_pedAS);
            r_pedLatch[1] <= ((r_state == c_ST_WALK) && r_owner)  ? 1'b0
                                                                  : (r_pedLatch[1] | w_pedBS);
        end
    end

    always_comb begin
        outLightA   = 2'b00;
        outLightB   = 2'b00;
        if (r_owner) begin
            outLightB = r_state;
        end else begin
            outLightA = r_state;
        end
        outPedLatch = r_pedLatch;
        outOwner    = r_owner;
    end

endmodule
`default_nettype wire

// File: doc/intersection_scheduler.md
# intersection_scheduler

Right-of-way scheduler for a two-approach intersection (approach A, approach B). It shares the crossing between the two approaches. It sequences green, yellow, walk and all-red clearance phases, and alternates ownership round-robin. Each approach's light is driven with the same 2-bit light code used by the single-approach traffic light. Timing is counted in ticks derived from the external blinker.

## Interface

Parameters (all values in ticks; each must be ≤ 255):
- C_MIN_GREEN, 50: minimum green before a yield to a competing demand.
- C_MAX_GREEN, 200: maximum green; unconditional yield. Must be ≥ C_MIN_GREEN.
- C_YELLOW, 20: yellow interval.
- C_ALLRED, 10: all-red clearance interval.
- C_WALK, 100: pedestrian walk interval.

Ports:
- clk  in  1  master clock.
- rstb  in  1  reset, asynchronous, active-low.
- blink  in  1  timebase from the blinker; asynchronous to clk.
- inTrafficA, inTrafficB  in  1 each  vehicle sensor per approach; asynchronous.
- inPedA, inPedB  in  1 each  pedestrian button per approach; debounced upstream; asynchronous.
- inHold  in  1  1 = do not grant a new phase (intersection held all-red).
- outLightA, outLightB  out  2 each  light code: 00 red, 01 green, 10 yellow, 11 walk.
- outPedLatch  out  2  [0] = A request pending, [1] = B request pending.
- outOwner  out  1  current or last owner: 0 = A, 1 = B.

## Operation

- **Synchronisers:** blink, inTraffic*, inPed* and inHold each pass through a 2-FF synchroniser. Only synchronised versions are used.
- **Tick:** a one-clk pulse on each synchronised rising edge of blink. There is exactly one tick per edge, independent of the high time.
- **Timer:** 8-bit.
  - Cleared to 0 on every clk edge where the state changes.
  - Otherwise +1 on a tick, saturating at 255.
- **Ped latches:**
  - Set on any clk with the synchronised inPedX = 1.
  - Cleared while state = WALK and owner = X. The clear dominates the set.
- **Demand:** demandX = trafficX | pedLatchX.
- **States:**
  - **ALLRED.**
    - Exit when timer ≥ C_ALLRED and inHold = 0.
    - Next owner is the other approach if demandOther = 1 or demandOwner = 0. Otherwise the owner is unchanged.
    - Go to WALK if the new owner's pedLatch = 1, else GREEN. The owner register updates on the same edge.
  - **GREEN:** go to YELLOW when timer ≥ C_MAX_GREEN, or when timer ≥ C_MIN_GREEN and demandOther = 1.
  - **YELLOW:** go to ALLRED when timer ≥ C_YELLOW.
  - **WALK:** go to ALLRED when timer ≥ C_WALK. No yellow follows a walk phase.
  - **Illegal encoding:** go to ALLRED.
- **Outputs:**
  - The owner light shows the state code: GREEN 01, YELLOW 10, WALK 11, ALLRED 00.
  - The non-owner light is always 00.
  - The two lights are never both non-00.
  - Outputs are a combinational decode of the state and owner registers only.
- **Reset (async, immediate):**
  - State = ALLRED, owner = 1 (B), so the first grant evaluates A.
  - Timer = 0, latches = 0, synchronisers = 0.
  - outLightA = outLightB = 00, outPedLatch = 00, outOwner = 1.
- **Simultaneous events:**
  - Both approaches have demand at the ALLRED exit: alternate.
  - Ped latch and traffic present on the same approach: WALK wins.
  - inHold asserted in GREEN, YELLOW or WALK: the phase completes normally, and the block then holds in ALLRED.
  - A ped press during the owner's own GREEN latches and is served at that approach's next grant.

## Timing

- Input to internal use: 2 clk (synchroniser).
- Tick: 2–3 clk after a blink rise. blink must be stable high and low for ≥ 3 clk each.
- State change: registered. The exit condition is evaluated each clk, and the state and timer update on the next edge.
- Phase length with parameter N:
  - N ticks plus up to 1 clk.
  - N = 0 gives a 1-clk phase.
- Ped latch:
  - outPedLatch rises 3 clk after the button (2-FF synchroniser plus the latch register).
  - Clears 1 clk after entry to WALK for that approach.
- Lights change on the same clk edge as the state.

## Test plan

Bench parameters: C_MIN_GREEN = 4, C_MAX_GREEN = 8, C_YELLOW = 2, C_ALLRED = 1, C_WALK = 3; blink period 20 clk.

1. **Reset then idle** (all inputs 0):
   - Lights 00/00 and outOwner = 1 during reset.
   - After 1 tick: A = 01 for 8 ticks, A = 10 for 2 ticks, 00/00 for 1 tick.
   - Then B = 01 (alternation with no demand).
2. **Persistent own demand** (inTrafficA = 1, inTrafficB = 0): A green 8 ticks, yellow 2, all-red 1, then A green again with outOwner = 0.
3. **Competing pedestrian** (pulse inPedB during A green at tick 1):
   - outPedLatch = 10.
   - A yellow at tick 4, all-red, then B = 11 for 3 ticks.
   - Latch clears 1 clk after WALK entry; then all-red.
4. **Hold** (inHold = 1 during A yellow):
   - Yellow completes, then 00/00 is held indefinitely.
   - On release, the grant occurs within 3 clk (timer already ≥ C_ALLRED).
5. **Mid-phase reset** (rstb low during B walk): outputs 00/00, outPedLatch = 00 and outOwner = 1 with no clk edge required.
6. **Tick integrity** (blink held high 50 clk): exactly one tick, so the timer advances by exactly 1.
